// File: rtl/alu_defs.sv
// Shared definitions for the ALU blocks: FSM state encoding and default datapath width.
package alu_defs;

  localparam int unsigned WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_32_if.sv
// Request/result bundle for the iterative divider.
interface div_32_if
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Rm;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, A, B,
    input  Q, Rm, busy, done, div_zero
  );

  modport slave (
    input  start, A, B,
    output Q, Rm, busy, done, div_zero
  );
endinterface

// File: rtl/sub_32.sv
// 32-bit combinational subtractor, R = A - B (modulo 2^32).
module sub_32 (
  output logic [31:0] R,
  input  logic [31:0] A,
  input  logic [31:0] B
);
  assign R = A - B;
endmodule

// File: rtl/div_32.sv
// Unsigned restoring divider, one quotient bit per cycle MSB first; B==0 short-circuits to DONE.
module div_32
  import alu_defs::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input logic      clk,
  input logic      rst,
  div_32_if.slave  bus
);

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] rem;
  logic [5:0]       cnt;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] rm_r;
  logic             busy_r;
  logic             done_r;
  logic             dz_r;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] trial;
  logic             borrow;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] dvd_nx;

  assign rem_sh = {rem, dvd[WIDTH-1]};

  sub_32 u_sub (
    .R (trial),
    .A (rem_sh[WIDTH-1:0]),
    .B (dsr)
  );

  // The shifted remainder is one bit wider than the subtractor, so borrow
  // comes from a full-width compare; when it does not borrow the difference
  // is known to fit back into WIDTH bits.
  assign borrow = (rem_sh < {1'b0, dsr});
  assign rem_nx = borrow ? rem_sh[WIDTH-1:0] : trial;
  // Quotient bits shift into the dividend register as its bits are consumed.
  assign dvd_nx = {dvd[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dvd    <= '0;
      dsr    <= '0;
      rem    <= '0;
      cnt    <= '0;
      q_r    <= '0;
      rm_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.B == '0) begin
              q_r    <= '1;
              rm_r   <= bus.A;
              dz_r   <= 1'b1;
              done_r <= 1'b1;
              state  <= DONE;
            end else begin
              dvd    <= bus.A;
              dsr    <= bus.B;
              rem    <= '0;
              cnt    <= '0;
              busy_r <= 1'b1;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          rem <= rem_nx;
          dvd <= dvd_nx;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(WIDTH - 1)) begin
            q_r    <= dvd_nx;
            rm_r   <= rem_nx;
            dz_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.Q        = q_r;
  assign bus.Rm       = rm_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.div_zero = dz_r;

endmodule

// File: tb/tb_div_32.sv
// Directed and random checks of div_32 against a quotient/remainder scoreboard.
module tb_div_32;
  import alu_defs::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  div_32_if #(.WIDTH(32)) bus ();

  div_32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] rm;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 32'd0) begin
      e.q  = 32'hFFFF_FFFF;
      e.rm = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.rm = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Launch one division; poke_k >= 0 re-pulses start with new operands in that RUN cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int poke_k);
    exp_t        e;
    int          k;
    int          busy_n;
    logic [63:0] prod;
    sb.push_back(model(a, b));
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    k      = 0;
    busy_n = 0;
    while (!bus.done && k < 40) begin
      if (bus.busy) busy_n++;
      if (k == poke_k) begin
        bus.start = 1'b1;
        bus.A     = $urandom;
        bus.B     = $urandom;
      end
      tick();
      bus.start = 1'b0;
      k++;
    end
    e = sb.pop_front();
    check("done_latency", 64'(k), (e.b == 32'd0) ? 64'd0 : 64'd32);
    check("busy_cycles", 64'(busy_n), (e.b == 32'd0) ? 64'd0 : 64'd32);
    check("busy_with_done", {63'd0, bus.busy}, 64'd0);
    check("q", {32'd0, bus.Q}, {32'd0, e.q});
    check("rm", {32'd0, bus.Rm}, {32'd0, e.rm});
    check("div_zero", {63'd0, bus.div_zero}, {63'd0, e.dz});
    if (e.b != 32'd0) begin
      prod = {32'd0, bus.Q} * {32'd0, e.b} + {32'd0, bus.Rm};
      check("identity", prod, {32'd0, e.a});
      check("rm_lt_b", {63'd0, (bus.Rm < e.b)}, 64'd1);
    end
    tick();
    check("done_one_cycle", {63'd0, bus.done}, 64'd0);
    check("busy_after_done", {63'd0, bus.busy}, 64'd0);
    check("q_hold", {32'd0, bus.Q}, {32'd0, e.q});
    check("rm_hold", {32'd0, bus.Rm}, {32'd0, e.rm});
  endtask

  initial begin
    int          done_seen;
    logic [31:0] ra;
    logic [31:0] rb;

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    tick();
    tick();
    check("rst_q", {32'd0, bus.Q}, 64'd0);
    check("rst_rm", {32'd0, bus.Rm}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_done", {63'd0, bus.done}, 64'd0);
    check("rst_dz", {63'd0, bus.div_zero}, 64'd0);

    // First start coincides with the first cycle of rst low.
    rst = 1'b0;
    do_op(32'd32, 32'd7, -1);
    do_op(32'd7, 32'd32, -1);
    do_op(32'hFFFF_FFFF, 32'd1, -1);
    do_op(32'd100, 32'd0, -1);
    do_op(32'd1000, 32'd10, 5);
    do_op(32'd12345, 32'd12345, -1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    do_op(32'h8000_0000, 32'h7FFF_FFFF, -1);

    // Abort mid-RUN with reset: outputs clear, no done pulse follows.
    bus.A     = 32'd50;
    bus.B     = 32'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_q", {32'd0, bus.Q}, 64'd0);
    check("abort_rm", {32'd0, bus.Rm}, 64'd0);
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_dz", {63'd0, bus.div_zero}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      if (bus.done || bus.busy) done_seen++;
      tick();
    end
    check("abort_quiet", 64'(done_seen), 64'd0);
    do_op(32'd15, 32'd4, -1);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      if (i % 50 == 0)      rb = 32'd0;
      else if (i % 4 == 0)  rb = $urandom_range(15, 1);
      else if (i % 4 == 1)  rb = ra + 32'($urandom_range(3, 0));
      else                  rb = $urandom >> $urandom_range(31, 0);
      do_op(ra, rb, (i % 7 == 0) ? int'($urandom_range(30, 0)) : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_32.md
DIV_32 -- requirements
Module: div_32

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; only 32 is required to be supported.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 A  input  32  dividend, unsigned.
REQ-006 B  input  32  divisor, unsigned.
REQ-007 Q  output  32  quotient, registered.
REQ-008 Rm  output  32  remainder, registered.
REQ-009 busy  output  1  high while an operation is in progress (RUN state).
REQ-010 done  output  1  one-cycle pulse; Q/Rm/div_zero valid in that cycle.
REQ-011 div_zero  output  1  registered flag; set when the completed operation had B==0.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 IDLE, start=1 at edge N: capture A and B internally; clear the partial remainder; clear the bit counter; go to RUN.
REQ-014 IDLE, start=1 with B==0: go directly to DONE at edge N, with Q=32'hFFFFFFFF, Rm=A and div_zero=1.
REQ-015 RUN performs one restoring-division step per cycle, MSB first: shift {rem, dividend} left by 1; trial = rem - divisor.
REQ-016 If the trial does not borrow, the block SHALL keep it as rem and set the quotient bit to 1; otherwise it SHALL keep rem and set the quotient bit to 0.
REQ-017 After exactly 32 RUN steps (edge N+32), the FSM SHALL enter DONE.
REQ-018 On that same edge, Q and Rm SHALL be loaded with the final quotient and remainder, and div_zero SHALL be 0.
REQ-019 DONE lasts exactly one cycle: done=1 during DONE; the next edge returns to IDLE with done=0.
REQ-020 Q, Rm and div_zero SHALL hold their values in IDLE until the next completion or reset.
REQ-021 busy SHALL be 1 exactly while the state is RUN; done and busy are never 1 together.
REQ-022 start in RUN or DONE SHALL be ignored; it is not queued, and in-flight operands are unaffected.
REQ-023 A/B changes after the capture edge SHALL NOT affect the result.
REQ-024 The results SHALL satisfy A == Q*B + Rm and Rm < B for all B != 0, including A < B (Q=0, Rm=A) and A == B (Q=1, Rm=0).
REQ-025 The bit counter SHALL be 6 bits and SHALL NOT wrap within an operation.

Reset
REQ-026 With rst=1 at an edge: state=IDLE; Q=0, Rm=0, busy=0, done=0, div_zero=0; counter and internal registers cleared.
REQ-027 Reset SHALL take priority over start and over any in-progress RUN or DONE; the aborted operation produces no done pulse.
REQ-028 The first start SHALL be accepted on the first edge with rst=0.

Structure
REQ-029 State encodings (IDLE/RUN/DONE) and the WIDTH default SHALL reside in a shared package/include (alu_defs) used by the ALU blocks.
REQ-030 The per-step trial subtraction SHALL instantiate the existing 32-bit combinational subtractor sub_32, with port order (R, A, B).
REQ-031 Borrow SHALL be derived from a 33-bit compare or from an extended MSB; no second sub-module is required.

Verification
REQ-032 A=32, B=7, start pulse -> after 32 busy cycles, done=1 with Q=4, Rm=4, div_zero=0.
REQ-033 A=7, B=32 -> Q=0, Rm=7; then A=32'hFFFFFFFF, B=1 -> Q=32'hFFFFFFFF, Rm=0.
REQ-034 A=100, B=0 -> done on the cycle after the start edge with Q=32'hFFFFFFFF, Rm=100, div_zero=1, and busy never asserted.
REQ-035 Start A=1000, B=10, then change A/B and pulse start at cycle 5 of RUN -> second start ignored; result Q=100, Rm=0 at edge N+32.
REQ-036 Reset at cycle 10 of RUN -> all outputs 0 next cycle, with no done pulse; then start A=15, B=4 -> Q=3, Rm=3.
REQ-037 A self-checking random loop of at least 1000 pairs SHALL verify A == Q*B + Rm and Rm < B, with exactly one done per accepted start.
